// File: rtl/gsp_pkg.sv
// Shared types and constants for the grid symbol painter.
//   gsp_state_e : painter FSM states
//   SYM_*       : symbol codes stored in the readback table
//   COL_*       : ink colour of each symbol's shape pixels
//   LFSR_TAPS   : feedback mask for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
package gsp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCard,
    StPick,
    StSym,
    StDone
  } gsp_state_e;

  localparam logic [1:0] SYM_FILL = 2'd0;
  localparam logic [1:0] SYM_BOX  = 2'd1;
  localparam logic [1:0] SYM_X    = 2'd2;
  localparam logic [1:0] SYM_PLUS = 2'd3;

  localparam logic [2:0] COL_FILL = 3'b100;
  localparam logic [2:0] COL_BOX  = 3'b001;
  localparam logic [2:0] COL_X    = 3'b010;
  localparam logic [2:0] COL_PLUS = 3'b011;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, shifts left every clock out of reset.
//   clk     : system clock
//   reset_n : asynchronous active-low reset, loads seed (0 replaced by 8'h01)
//   seed    : reset value, expected to be tied to a constant
//   q       : current LFSR state
module lfsr8
  import gsp_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] seed_safe;

  // An all-zero state would lock the register up.
  assign seed_safe = (seed == 8'h00) ? 8'h01 : seed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= seed_safe;
    end else begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/grid_symbol_painter.sv
// Paints a card background, then a ROWS x COLS grid of pseudo-random symbols,
// one pixel per clock, and keeps each cell's symbol code for readback.
//   clk, reset_n     : clock, asynchronous active-low reset
//   start            : one-cycle paint request (ignored while busy)
//   rd_row, rd_col   : readback cell index; rd_sym is its code (0 if out of range)
//   x, y, colour     : registered pixel stream, qualified by writeEn
//   busy, done       : paint in progress / paint finished
module grid_symbol_painter
  import gsp_pkg::*;
#(
  parameter int unsigned ROWS        = 3,
  parameter int unsigned COLS        = 3,
  parameter int unsigned X0          = 50,
  parameter int unsigned Y0          = 30,
  parameter int unsigned PITCH_X     = 20,
  parameter int unsigned PITCH_Y     = 20,
  parameter int unsigned SYM_W       = 8,
  parameter int unsigned SYM_H       = 8,
  parameter int unsigned NUM_SYMBOLS = 3,
  parameter int unsigned DRAW_CARD   = 1,
  parameter int unsigned CARD_X      = 40,
  parameter int unsigned CARD_Y      = 20,
  parameter int unsigned CARD_W      = 72,
  parameter int unsigned CARD_H      = 72,
  parameter logic [2:0]  CARD_COLOUR = 3'b111,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] rd_row,
  input  logic [1:0] rd_col,
  output logic [1:0] rd_sym,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       done
);

  if (ROWS < 1 || ROWS > 4 || COLS < 1 || COLS > 4 || SYM_W < 2 || SYM_W > 16 ||
      SYM_H < 2 || SYM_H > 16 || NUM_SYMBOLS < 2 || NUM_SYMBOLS > 4 ||
      X0 + (COLS - 1) * PITCH_X + SYM_W > 160 || Y0 + (ROWS - 1) * PITCH_Y + SYM_H > 120 ||
      (DRAW_CARD != 0 && (CARD_W < 1 || CARD_H < 1 ||
                          CARD_X + CARD_W > 160 || CARD_Y + CARD_H > 120)))
  begin : g_param_check
    $error("grid_symbol_painter: parameter set is out of range or paints off-screen");
  end

  localparam logic [7:0] CardWm1   = 8'(CARD_W - 1);
  localparam logic [7:0] CardHm1   = 8'(CARD_H - 1);
  localparam logic [7:0] SymWm1    = 8'(SYM_W - 1);
  localparam logic [7:0] SymHm1    = 8'(SYM_H - 1);
  localparam logic [7:0] SymWHalf  = 8'(SYM_W / 2);
  localparam logic [7:0] SymHHalf  = 8'(SYM_H / 2);
  localparam logic [1:0] RowLast   = 2'(ROWS - 1);
  localparam logic [1:0] ColLast   = 2'(COLS - 1);
  localparam gsp_state_e StFirst   = (DRAW_CARD != 0) ? StCard : StPick;

  gsp_state_e state_q;
  logic [7:0] u_q, v_q;
  logic [1:0] row_q, col_q, code_q;
  logic [1:0] sym_tab_q [4][4];
  logic [7:0] lfsr_q;
  logic [8:0] base_x, base_y;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       unused_lfsr_hi;

  lfsr8 u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .seed   (SEED),
    .q      (lfsr_q)
  );

  // Only the low two bits pick a symbol; the rest is LFSR-internal state.
  assign unused_lfsr_hi = ^lfsr_q[7:2];

  function automatic logic [2:0] shape_colour(input logic [1:0] code, input logic [7:0] u,
                                              input logic [7:0] v);
    logic       hit;
    logic [2:0] ink;
    case (code)
      SYM_FILL: begin
        hit = 1'b1;
        ink = COL_FILL;
      end
      SYM_BOX: begin
        hit = (u == 8'd0) || (v == 8'd0) || (u == SymWm1) || (v == SymHm1);
        ink = COL_BOX;
      end
      SYM_X: begin
        hit = (u == v) || (({1'b0, u} + {1'b0, v}) == {1'b0, SymWm1});
        ink = COL_X;
      end
      default: begin
        hit = (u == SymWHalf) || (v == SymHHalf);
        ink = COL_PLUS;
      end
    endcase
    return hit ? ink : CARD_COLOUR;
  endfunction

  // 9-bit coordinate arithmetic, truncated onto the 8-bit x / 7-bit y bus.
  always_comb begin
    if (state_q == StCard) begin
      base_x = 9'(CARD_X);
      base_y = 9'(CARD_Y);
    end else begin
      base_x = 9'(X0 + 32'(col_q) * PITCH_X);
      base_y = 9'(Y0 + 32'(row_q) * PITCH_Y);
    end
    pix_x = 8'(base_x + {1'b0, u_q});
    pix_y = 7'(base_y + {1'b0, v_q});
  end

  assign rd_sym = (32'(rd_row) < ROWS && 32'(rd_col) < COLS) ? sym_tab_q[rd_row][rd_col] : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      u_q     <= '0;
      v_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      code_q  <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          sym_tab_q[i][j] <= '0;
        end
      end
    end else begin
      writeEn <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFirst;
            busy    <= 1'b1;
            u_q     <= '0;
            v_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        StCard: begin
          x       <= pix_x;
          y       <= pix_y;
          colour  <= CARD_COLOUR;
          writeEn <= 1'b1;
          if (u_q == CardWm1) begin
            u_q <= '0;
            if (v_q == CardHm1) begin
              v_q     <= '0;
              state_q <= StPick;
            end else begin
              v_q <= v_q + 8'd1;
            end
          end else begin
            u_q <= u_q + 8'd1;
          end
        end
        StPick: begin
          // Out-of-range codes are rejected; retry with next cycle's LFSR value.
          if (32'(lfsr_q[1:0]) < NUM_SYMBOLS) begin
            sym_tab_q[row_q][col_q] <= lfsr_q[1:0];
            code_q                  <= lfsr_q[1:0];
            state_q                 <= StSym;
          end
        end
        StSym: begin
          x       <= pix_x;
          y       <= pix_y;
          colour  <= shape_colour(code_q, u_q, v_q);
          writeEn <= 1'b1;
          if (u_q == SymWm1) begin
            u_q <= '0;
            if (v_q == SymHm1) begin
              v_q <= '0;
              if (row_q == RowLast && col_q == ColLast) begin
                state_q <= StDone;
              end else begin
                state_q <= StPick;
                if (col_q == ColLast) begin
                  col_q <= '0;
                  row_q <= row_q + 2'd1;
                end else begin
                  col_q <= col_q + 2'd1;
                end
              end
            end else begin
              v_q <= v_q + 8'd1;
            end
          end else begin
            u_q <= u_q + 8'd1;
          end
        end
        StDone: begin
          busy <= 1'b0;
          done <= 1'b1;
          // Qualify with done so the cycle right after the last pixel cannot restart.
          if (start && done) begin
            state_q <= StFirst;
            busy    <= 1'b1;
            done    <= 1'b0;
            u_q     <= '0;
            v_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_symbol_painter.sv
module tb_grid_symbol_painter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] rd_row = 2'd0;
  logic [1:0] rd_col = 2'd0;
  logic [1:0] rd_sym1, rd_sym2;
  logic [7:0] x1, x2;
  logic [6:0] y1, y2;
  logic [2:0] c1, c2;
  logic       we1, we2, busy1, busy2, done1, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grid_symbol_painter u_dut (
    .clk(clk), .reset_n(reset_n), .start(start1), .rd_row(rd_row), .rd_col(rd_col),
    .rd_sym(rd_sym1), .x(x1), .y(y1), .colour(c1), .writeEn(we1), .busy(busy1), .done(done1)
  );

  grid_symbol_painter #(.ROWS(2), .COLS(4), .DRAW_CARD(0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .rd_row(rd_row), .rd_col(rd_col),
    .rd_sym(rd_sym2), .x(x2), .y(y2), .colour(c2), .writeEn(we2), .busy(busy2), .done(done2)
  );

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shift left, seed A5.
  logic [7:0] m;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= 8'hA5;
    else          m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end

  bit         sel = 1'b0;
  logic [7:0] xs;
  logic [6:0] ys;
  logic [2:0] cs;
  logic       wes, busys, dones;
  always_comb begin
    xs = sel ? x2 : x1;
    ys = sel ? y2 : y1;
    cs = sel ? c2 : c1;
    wes = sel ? we2 : we1;
    busys = sel ? busy2 : busy1;
    dones = sel ? done2 : done1;
  end

  // Results of the last run_paint.
  int         r_bad, r_card_wr, r_sym_wr, r_early_done, r_timeout;
  logic [7:0] r_fx, r_tx, r_lx;
  logic [6:0] r_fy, r_ty, r_ly;
  logic [2:0] r_fc;
  logic       r_busy0, r_done0, r_fin_done, r_fin_busy, r_fin_we, r_stay;
  bit         r_first;
  string      r_msg;
  logic [1:0] codes [4][4];

  function automatic logic [2:0] exp_col(input logic [1:0] code, input int u, input int v);
    case (code)
      2'd0:    return 3'b100;
      2'd1:    return (u == 0 || v == 0 || u == 7 || v == 7) ? 3'b001 : 3'b111;
      2'd2:    return (u == v || u + v == 7) ? 3'b010 : 3'b111;
      default: return (u == 4 || v == 4) ? 3'b011 : 3'b111;
    endcase
  endfunction

  task automatic drive_start(input bit v);
    if (sel) start2 = v;
    else     start1 = v;
  endtask

  task automatic note(input string what, input int ax, input int ay, input int ac,
                      input int ex, input int ey, input int ec);
    if (r_bad == 0)
      r_msg = $sformatf("%s got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", what, ax, ay, ac, ex, ey, ec);
    r_bad++;
  endtask

  // Runs one paint in lockstep with the reference LFSR, recording stream deviations.
  task automatic run_paint(input int rows, input int cols, input bit card, input int pulse_at,
                           input int tr, input int tc);
    logic [1:0] pv;
    int         n, guard, ex, ey;
    logic [2:0] ec;
    r_bad = 0; r_card_wr = 0; r_sym_wr = 0; r_early_done = 0; r_timeout = 0;
    r_first = 1'b1; r_msg = ""; r_tx = '0; r_ty = '0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) codes[i][j] = '0;
    @(negedge clk); drive_start(1'b1);
    @(posedge clk); #1; drive_start(1'b0);
    r_busy0 = busys; r_done0 = dones;
    n = 0;
    if (card) begin
      for (int v = 0; v < 72; v++) begin
        for (int u = 0; u < 72; u++) begin
          @(posedge clk); #1; drive_start(1'b0);
          if (n == pulse_at) drive_start(1'b1);
          n++;
          if (dones) r_early_done++;
          if (wes === 1'b1) r_card_wr++;
          if (r_first) begin r_fx = xs; r_fy = ys; r_fc = cs; r_first = 1'b0; end
          if (wes !== 1'b1 || xs !== 8'(40 + u) || ys !== 7'(20 + v) || cs !== 3'b111)
            note("card", int'(xs), int'(ys), int'(cs), 40 + u, 20 + v, 7);
        end
      end
    end
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        guard = 0;
        do begin
          pv = m[1:0];
          @(posedge clk); #1;
          if (dones) r_early_done++;
          if (wes !== 1'b0) note("pick_we", int'(xs), int'(ys), int'(wes), 0, 0, 0);
          guard++;
        end while (pv == 2'd3 && guard < 64);
        if (guard >= 64) r_timeout++;
        codes[r][c] = pv;
        for (int sv = 0; sv < 8; sv++) begin
          for (int su = 0; su < 8; su++) begin
            @(posedge clk); #1;
            ex = 50 + 20 * c + su; ey = 30 + 20 * r + sv; ec = exp_col(pv, su, sv);
            if (dones) r_early_done++;
            if (wes === 1'b1) r_sym_wr++;
            if (r_first) begin r_fx = xs; r_fy = ys; r_fc = cs; r_first = 1'b0; end
            if (r == tr && c == tc && su == 0 && sv == 0) begin r_tx = xs; r_ty = ys; end
            r_lx = xs; r_ly = ys;
            if (wes !== 1'b1 || xs !== 8'(ex) || ys !== 7'(ey) || cs !== ec)
              note("sym", int'(xs), int'(ys), int'(cs), ex, ey, int'(ec));
          end
        end
      end
    end
    @(posedge clk); #1;
    r_fin_done = dones; r_fin_busy = busys; r_fin_we = wes;
    repeat (3) @(posedge clk);
    #1; r_stay = dones;
  endtask

  task automatic test_reset;
    int bad;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (x1 !== 8'd0) begin errors++; $display("FAIL reset_x got %0d want 0", x1); end
    checks++; if (y1 !== 7'd0) begin errors++; $display("FAIL reset_y got %0d want 0", y1); end
    checks++; if (c1 !== 3'd0) begin errors++; $display("FAIL reset_colour got %0d want 0", c1); end
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done1); end
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      rd_row = 2'(i); rd_col = 2'(j); #1;
      if (rd_sym1 !== 2'd0 || rd_sym2 !== 2'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_table nonzero entries %0d want 0", bad); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_full_paint;
    sel = 1'b0;
    run_paint(3, 3, 1'b1, -1, 1, 2);
    checks++; if (r_busy0 !== 1'b1) begin errors++; $display("FAIL full_busy_rise got %b want 1", r_busy0); end
    checks++; if (r_card_wr != 5184) begin errors++; $display("FAIL full_card_writes got %0d want 5184", r_card_wr); end
    checks++; if (r_sym_wr != 576) begin errors++; $display("FAIL full_sym_writes got %0d want 576", r_sym_wr); end
    checks++; if (r_fx !== 8'd40 || r_fy !== 7'd20 || r_fc !== 3'b111) begin errors++;
      $display("FAIL full_first_pixel got (%0d,%0d,c%0d) want (40,20,c7)", r_fx, r_fy, r_fc); end
    checks++; if (r_lx !== 8'd97 || r_ly !== 7'd77) begin errors++;
      $display("FAIL full_last_pixel got (%0d,%0d) want (97,77)", r_lx, r_ly); end
    checks++; if (r_bad != 0) begin errors++; $display("FAIL full_stream %0d bad cycles, first: %s", r_bad, r_msg); end
    checks++; if (r_timeout != 0) begin errors++; $display("FAIL full_pick_bound got %0d want 0", r_timeout); end
    checks++; if (r_early_done != 0) begin errors++; $display("FAIL full_early_done got %0d want 0", r_early_done); end
    checks++; if (r_fin_done !== 1'b1 || r_fin_busy !== 1'b0 || r_fin_we !== 1'b0) begin errors++;
      $display("FAIL full_done got done=%b busy=%b we=%b want 1,0,0", r_fin_done, r_fin_busy, r_fin_we); end
    checks++; if (r_stay !== 1'b1) begin errors++; $display("FAIL full_done_hold got %b want 1", r_stay); end
  endtask

  task automatic test_cell12;
    checks++; if (r_tx !== 8'd90 || r_ty !== 7'd50) begin errors++;
      $display("FAIL cell12_origin got (%0d,%0d) want (90,50)", r_tx, r_ty); end
    rd_row = 2'd1; rd_col = 2'd2; #1;
    checks++; if (rd_sym1 !== codes[1][2]) begin errors++;
      $display("FAIL cell12_code got %0d want %0d", rd_sym1, codes[1][2]); end
  endtask

  task automatic test_readback;
    int bad_match, bad_range;
    bad_match = 0; bad_range = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      rd_row = 2'(i); rd_col = 2'(j); #1;
      if (rd_sym1 !== ((i < 3 && j < 3) ? codes[i][j] : 2'd0)) bad_match++;
      if (rd_sym1 >= 2'd3) bad_range++;
    end
    checks++; if (bad_match != 0) begin errors++; $display("FAIL readback_table got %0d wrong want 0", bad_match); end
    checks++; if (bad_range != 0) begin errors++; $display("FAIL readback_range got %0d codes>=3 want 0", bad_range); end
  endtask

  task automatic test_start_ignored;
    sel = 1'b0;
    run_paint(3, 3, 1'b1, 100, 1, 2);
    checks++; if (r_done0 !== 1'b0) begin errors++; $display("FAIL restart_done_clear got %b want 0", r_done0); end
    checks++; if (r_bad != 0) begin errors++; $display("FAIL midstart_stream %0d bad cycles, first: %s", r_bad, r_msg); end
    checks++; if (r_card_wr != 5184 || r_sym_wr != 576) begin errors++;
      $display("FAIL midstart_writes got %0d/%0d want 5184/576", r_card_wr, r_sym_wr); end
    checks++; if (r_fin_done !== 1'b1) begin errors++; $display("FAIL midstart_done got %b want 1", r_fin_done); end
  endtask

  task automatic test_reset_mid_sym;
    int guard, bad;
    sel = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (5185) @(posedge clk);
    #1; guard = 0;
    while (we1 !== 1'b1 && guard < 64) begin @(posedge clk); #1; guard++; end
    checks++; if (guard >= 64) begin errors++; $display("FAIL midsym_reach got timeout want sym write"); end
    #2; reset_n = 1'b0; #1;
    checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL midsym_we_drop got %b want 0", we1); end
    checks++; if (busy1 !== 1'b0 || x1 !== 8'd0) begin errors++;
      $display("FAIL midsym_clear got busy=%b x=%0d want 0,0", busy1, x1); end
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      rd_row = 2'(i); rd_col = 2'(j); #1;
      if (rd_sym1 !== 2'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midsym_table got %0d nonzero want 0", bad); end
    @(negedge clk); reset_n = 1'b1;
    run_paint(3, 3, 1'b1, -1, 1, 2);
    checks++; if (r_fx !== 8'd40 || r_fy !== 7'd20) begin errors++;
      $display("FAIL fresh_first got (%0d,%0d) want (40,20)", r_fx, r_fy); end
    checks++; if (r_bad != 0) begin errors++; $display("FAIL fresh_stream %0d bad cycles, first: %s", r_bad, r_msg); end
    checks++; if (r_fin_done !== 1'b1) begin errors++; $display("FAIL fresh_done got %b want 1", r_fin_done); end
  endtask

  task automatic test_no_card;
    int bad;
    sel = 1'b1;
    run_paint(2, 4, 1'b0, -1, 1, 3);
    checks++; if (r_busy0 !== 1'b1) begin errors++; $display("FAIL nocard_busy got %b want 1", r_busy0); end
    checks++; if (r_card_wr != 0) begin errors++; $display("FAIL nocard_card_writes got %0d want 0", r_card_wr); end
    checks++; if (r_sym_wr != 512) begin errors++; $display("FAIL nocard_sym_writes got %0d want 512", r_sym_wr); end
    checks++; if (r_fx !== 8'd50 || r_fy !== 7'd30) begin errors++;
      $display("FAIL nocard_first got (%0d,%0d) want (50,30)", r_fx, r_fy); end
    checks++; if (r_tx !== 8'd110 || r_ty !== 7'd50) begin errors++;
      $display("FAIL nocard_cell13 got (%0d,%0d) want (110,50)", r_tx, r_ty); end
    checks++; if (r_bad != 0) begin errors++; $display("FAIL nocard_stream %0d bad cycles, first: %s", r_bad, r_msg); end
    checks++; if (r_fin_done !== 1'b1 || r_fin_busy !== 1'b0) begin errors++;
      $display("FAIL nocard_done got done=%b busy=%b want 1,0", r_fin_done, r_fin_busy); end
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      rd_row = 2'(i); rd_col = 2'(j); #1;
      if (rd_sym2 !== ((i < 2) ? codes[i][j] : 2'd0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL nocard_table got %0d wrong want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_full_paint;
    test_cell12;
    test_readback;
    test_start_ignored;
    test_reset_mid_sym;
    test_no_card;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
